// File: rtl/shift_add_mult_pkg.sv
// Shared types for the shift-add multiplier.
// FSM state encoding and count-width helper.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// lookAheadCarryAdder: 4-bit-group carry-lookahead adder.
// Width is padded up to a multiple of 4 internally.
module lookAheadCarryAdder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    localparam int NB = (N + 3) / 4;
    localparam int NP = NB * 4;

    logic [NP-1:0] ap;
    logic [NP-1:0] bp;
    logic [NP-1:0] g;
    logic [NP-1:0] p;
    logic [NP:0]   cv;
    logic [NP-1:0] s;

    assign ap    = NP'(a);
    assign bp    = NP'(b);
    assign g     = ap & bp;
    assign p     = ap ^ bp;
    assign cv[0] = c_in;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        localparam int B = 4 * k;
        logic gb;
        logic pb;

        assign cv[B+1] = g[B] | (p[B] & cv[B]);
        assign cv[B+2] = g[B+1] | (p[B+1] & g[B])
                       | (p[B+1] & p[B] & cv[B]);
        assign cv[B+3] = g[B+2] | (p[B+2] & g[B+1])
                       | (p[B+2] & p[B+1] & g[B])
                       | (p[B+2] & p[B+1] & p[B] & cv[B]);

        // Group generate/propagate feed the next block's carry-in
        assign gb = g[B+3] | (p[B+3] & g[B+2])
                  | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign pb = &p[B+3:B];
        assign cv[B+4] = gb | (pb & cv[B]);
    end

    assign s     = p ^ cv[NP-1:0];
    assign sum   = s[N-1:0];
    assign c_out = cv[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier, N x N -> 2N.
// Define SHIFT_ADD_MULT_EARLY_TERM_EN to stop once multiplier bits run out.
module shift_add_multiplier #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    import shift_add_mult_pkg::*;

    localparam int CW = cnt_w(N);

    state_t          state;
    state_t          state_n;
    logic [2*N-1:0]  mcand;
    logic [N-1:0]    mplier;
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  sum;
    logic [CW-1:0]   count;
    logic            last;
    logic            accept;

    lookAheadCarryAdder #(
        .N(2 * N)
    ) u_add (
        .a    (acc),
        .b    (mcand),
        .c_in (1'b0),
        .sum  (sum),
        .c_out()
    );

    assign accept = (state == IDLE) && in_valid;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    assign last = (count == CW'(N - 1))
                || (mplier[N-1:1] == '0);
`else
    assign last = (count == CW'(N - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
                    state_n = (b == '0) ? DONE : RUN;
`else
                    state_n = RUN;
`endif
                end
            end
            RUN:     if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (accept) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (state == RUN) begin
            if (mplier[0]) acc <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign product   = acc;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized bench for shift_add_multiplier against an a*b model.
// Latency expectations follow SHIFT_ADD_MULT_EARLY_TERM_EN.
module tb_shift_add_multiplier;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    shift_add_multiplier #(
        .N(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edges from acceptance (counted as 1) until out_valid is seen
    function automatic int ref_lat(input logic [N-1:0] bv);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        if (bv == '0) return 1;
        for (int i = N - 1; i >= 0; i--)
            if (bv[i]) return i + 2;
        return 1;
`else
        return N + 1;
`endif
    endfunction

    task automatic run_op(input logic [N-1:0] av,
                          input logic [N-1:0] bv,
                          input int stall);
        int edges;
        int runcnt;
        int lat;
        logic [63:0] exp;
        exp = longint'(av) * longint'(bv);
        lat = ref_lat(bv);
        @(negedge clk);
        check("idle_rdy", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        edges    = 1;
        runcnt   = 0;
        while (!out_valid && edges < 200) begin
            if (!in_ready && busy) runcnt++;
            a        = N'($urandom);
            b        = N'($urandom);
            in_valid = 1'($urandom);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("latency", 64'(edges), 64'(lat));
        check("run_cycles", 64'(runcnt), 64'(lat - 1));
        check("done_flags", {62'd0, in_ready, busy}, 64'd0);
        check("product", 64'(product), exp);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom);
            a        = N'($urandom);
            b        = N'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_prod", 64'(product), exp);
            check("hold_state", {62'd0, out_valid, in_ready}, 64'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("ret_idle", {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         spurious;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        check("rst_rdy", 64'(in_ready), 64'd1);
        check("rst_vld", {62'd0, out_valid, busy}, 64'd0);
        check("rst_prod", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd3, 16'd5, 0);
        run_op(16'hFFFF, 16'hFFFF, 0);
        run_op(16'd0, 16'h1234, 0);
        run_op(16'h8001, 16'd0, 0);
        run_op(16'd7, 16'd0, 0);
        run_op(16'd9, 16'd4, 0);
        run_op(16'hABCD, 16'h8000, 5);
        run_op(16'd1, 16'd1, 2);

        // Reset pulse in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h1357;
        b        = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_rdy", 64'(in_ready), 64'd1);
        check("arst_flags", {62'd0, out_valid, busy}, 64'd0);
        check("arst_prod", 64'(product), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        spurious = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid || !in_ready) spurious = 1'b1;
        end
        check("no_spurious", 64'(spurious), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (i % 97 == 0) rb = '0;
            if (i % 89 == 0) ra = '0;
            if (i % 83 == 0) rb = N'($urandom_range(0, 15));
            if (i % 71 == 0) begin
                ra = '1;
                rb = '1;
            end
            run_op(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, operand pair on a/b is valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 SHALL have port a, input, N, unsigned multiplicand.
REQ-007 SHALL have port b, input, N, unsigned multiplier.
REQ-008 SHALL have port out_valid, output, 1, product is valid.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the product.
REQ-010 SHALL have port product, output, 2N, unsigned a*b.
REQ-011 SHALL have port busy, output, 1, high while in RUN state.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL drive in_ready = (state == IDLE), busy = (state == RUN) and out_valid = (state == DONE).
REQ-014 SHALL accept operands on a rising edge with in_valid && in_ready, capturing: multiplicand register (2N bits) = zero-extended a; multiplier register = b; accumulator = 0; count = 0; next state RUN.
REQ-015 SHALL ignore a/b/in_valid outside the acceptance edge; changes during RUN/DONE have no effect.
REQ-016 SHALL per RUN cycle: if multiplier[0] then accumulator <= accumulator + multiplicand (2N-bit sum, carry-out discarded, cannot overflow); multiplicand <<= 1; multiplier >>= 1; count += 1.
REQ-017 SHALL leave RUN for DONE on the edge completing the N-th RUN cycle (baseline), making out_valid rise N+1 edges after the acceptance edge.
REQ-018 SHALL drive product from the accumulator; it SHALL hold stable while out_valid && !out_ready.
REQ-019 SHALL return DONE -> IDLE on a rising edge with out_ready high; a new acceptance is possible no earlier than the following edge (no same-cycle turnaround).
REQ-020 SHALL hold count width $clog2(N)+1 so count == N is representable without wrap.
REQ-021 SHALL produce correct results at boundaries: a=0 or b=0 -> 0; a=b=2^N-1 -> (2^N-1)^2.

Reset
REQ-022 SHALL on rst_n low, immediately (asynchronously) force state IDLE, accumulator/multiplicand/multiplier/count to 0; hence product=0, out_valid=0, busy=0, in_ready=1.
REQ-023 SHALL abort any in-flight multiply on reset mid-RUN or mid-DONE; no out_valid for the aborted operation after reset release.

Configuration
REQ-024 SHALL support macro SHIFT_ADD_MULT_EARLY_TERM_EN (early termination).
REQ-025 SHALL without the macro always spend exactly N RUN cycles (fixed latency, REQ-017).
REQ-026 SHALL with the macro go from RUN to DONE on the first edge where the updated multiplier register is 0 (or count reaches N); at acceptance with b==0 go directly IDLE -> DONE, out_valid rising 1 edge after acceptance, product 0.
REQ-027 SHALL with the macro give RUN cycle count = (index of highest set bit of b) + 1; products identical to baseline.

Structure
REQ-028 SHALL place the FSM state enum typedef and the count-width constant function in shared package shift_add_mult_pkg.
REQ-029 SHALL instantiate one sub-module: the team's lookAheadCarryAdder with N=2N, c_in tied 0, c_out unconnected, as the accumulate adder.

Verification
REQ-030 SHALL cover: N=16, a=3, b=5, out_ready=1 -> product=15, out_valid rises 17 edges after acceptance (baseline).
REQ-031 SHALL cover: a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001; in_ready low for 17 edges after acceptance.
REQ-032 SHALL cover: out_ready held low 5 cycles in DONE with a/b/in_valid toggling -> product/out_valid stable, in_ready low, no new acceptance; then out_ready=1 -> IDLE next edge.
REQ-033 SHALL cover: rst_n pulsed low at RUN cycle 7 -> outputs at reset values asynchronously; after release in_ready=1, no spurious out_valid.
REQ-034 SHALL cover with SHIFT_ADD_MULT_EARLY_TERM_EN: a=7, b=0 -> product 0 after 1 edge; a=9, b=4 -> product 36 after 3 RUN cycles (out_valid 4 edges after acceptance).
REQ-035 SHALL cover: 1000 random back-to-back operand pairs with random out_ready stalls, compared against a*b reference model.
